// File: rtl/cycle_seq_if.sv
// Opcode/cycle sequencer to decoder link: data bus, raw pins, decoder strobes, request outputs.
// Latency: none, this is wiring only.
// Backpressure: none; the decoder throttles the sequencer through the scyc stall strobe.
interface cycle_seq_if;
    logic [7:0] databus;
    logic       irq_pin;
    logic       nmi_pin;
    logic       idis;
    logic       icyc;
    logic       rcyc;
    logic       scyc;
    logic       sinst;
    logic [7:0] inst;
    logic [2:0] cycle;
    logic       rstreq;
    logic       nmireq;
    logic       irqreq;
    logic       newinst;
    logic       cycerr;

    // Driver side: decoder / pins / data bus
    modport master (
        output databus, irq_pin, nmi_pin, idis, icyc, rcyc, scyc, sinst,
        input  inst, cycle, rstreq, nmireq, irqreq, newinst, cycerr
    );

    // Sequencer side
    modport slave (
        input  databus, irq_pin, nmi_pin, idis, icyc, rcyc, scyc, sinst,
        output inst, cycle, rstreq, nmireq, irqreq, newinst, cycerr
    );
endinterface

// File: rtl/cycle_seq.sv
// Opcode register and machine-cycle sequencer feeding the 6502 decoder; holds reset/NMI requests.
// Latency: strobes act on the next edge; NMI pin->nmireq 3 edges, IRQ pin->irqreq 2 edges.
// Backpressure: scyc stalls the cycle count; pending requests wait for rcyc/sinst.
module cycle_seq #(
    parameter logic [7:0] RSTVEC_OP = 8'h00
) (
    input  logic        clk,
    input  logic        clr,
    cycle_seq_if.slave  bus
);

    logic       irq_m, irq_s;
    logic       nmi_m, nmi_s, nmi_d;
    logic       nmi_edge;
    logic       rstpend, nmipend;
    logic       irqreq;
    logic [7:0] inst_q;
    logic [2:0] cycle_q;
    logic       newinst_q;
    logic       cycerr_q;

    // IRQ is level, so it is not latched; masking uses the live I flag.
    assign nmi_edge = nmi_s & ~nmi_d;
    assign irqreq   = irq_s & ~bus.idis;

    // Two-flop synchronisers for both pins, plus a delay flop for NMI edge detection.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            irq_m <= 1'b0;
            irq_s <= 1'b0;
            nmi_m <= 1'b0;
            nmi_s <= 1'b0;
            nmi_d <= 1'b0;
        end else begin
            irq_m <= bus.irq_pin;
            irq_s <= irq_m;
            nmi_m <= bus.nmi_pin;
            nmi_s <= nmi_m;
            nmi_d <= nmi_s;
        end
    end

    // Pending reset/NMI; sinst retires reset first, then NMI. A fresh NMI edge beats the clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rstpend <= 1'b1;
            nmipend <= 1'b0;
        end else begin
            if (bus.sinst && rstpend) begin
                rstpend <= 1'b0;
            end
            if (nmi_edge) begin
                nmipend <= 1'b1;
            end else if (bus.sinst && !rstpend && nmipend) begin
                nmipend <= 1'b0;
            end
        end
    end

    // Cycle counter (rcyc > scyc > icyc) with sticky wrap error.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cycle_q  <= 3'd0;
            cycerr_q <= 1'b0;
        end else if (bus.rcyc) begin
            cycle_q <= 3'd0;
        end else if (bus.scyc) begin
            cycle_q <= cycle_q;
        end else if (bus.icyc) begin
            cycle_q <= cycle_q + 3'd1;
            if (cycle_q == 3'd7) begin
                cycerr_q <= 1'b1;
            end
        end
    end

    // Opcode fetch: any pending request substitutes the reset/interrupt vector opcode.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            inst_q    <= RSTVEC_OP;
            newinst_q <= 1'b0;
        end else begin
            newinst_q <= bus.rcyc;
            if (bus.rcyc) begin
                inst_q <= (rstpend || nmipend || irqreq) ? RSTVEC_OP : bus.databus;
            end
        end
    end

    assign bus.inst    = inst_q;
    assign bus.cycle   = cycle_q;
    assign bus.rstreq  = rstpend;
    assign bus.nmireq  = nmipend;
    assign bus.irqreq  = irqreq;
    assign bus.newinst = newinst_q;
    assign bus.cycerr  = cycerr_q;

endmodule

// File: tb/tb_cycle_seq.sv
// Self-checking bench for cycle_seq: directed plan steps then randomized traffic vs a reference model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives every strobe directly.
module tb_cycle_seq;

    localparam logic [7:0] RSTVEC = 8'h00;

    logic clk = 1'b0;
    logic clr = 1'b0;
    cycle_seq_if bus ();

    cycle_seq #(.RSTVEC_OP(RSTVEC)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: architectural state plus pin history (index 0 = most recent edge sample).
    logic [7:0] m_inst;
    int         m_cycle;
    bit         m_rst, m_nmi, m_new, m_err;
    bit         ih [0:3];
    bit         nh [0:3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_irqreq();
        return ih[1] & ~bus.idis;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".inst"},    32'(bus.inst),    32'(m_inst));
        check({tag, ".cycle"},   32'(bus.cycle),   32'(m_cycle));
        check({tag, ".rstreq"},  32'(bus.rstreq),  32'(m_rst));
        check({tag, ".nmireq"},  32'(bus.nmireq),  32'(m_nmi));
        check({tag, ".irqreq"},  32'(bus.irqreq),  32'(m_irqreq()));
        check({tag, ".newinst"}, 32'(bus.newinst), 32'(m_new));
        check({tag, ".cycerr"},  32'(bus.cycerr),  32'(m_err));
    endtask

    task automatic model_reset();
        m_inst  = RSTVEC;
        m_cycle = 0;
        m_rst   = 1'b1;
        m_nmi   = 1'b0;
        m_new   = 1'b0;
        m_err   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ih[k] = 1'b0;
            nh[k] = 1'b0;
        end
    endtask

    // Asynchronous reset pulse between edges: outputs must return to reset values at once.
    task automatic do_reset(input string tag);
        clr = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1;
        clr = 1'b0;
    endtask

    // One clock edge with the given strobes; model advanced from pre-edge state, then compared.
    task automatic step(input string tag, input bit r, input bit s, input bit i,
                        input bit si, input logic [7:0] db);
        bit irqr, nedge;
        bus.rcyc    = r;
        bus.scyc    = s;
        bus.icyc    = i;
        bus.sinst   = si;
        bus.databus = db;
        irqr  = m_irqreq();
        nedge = nh[1] & ~nh[2];
        if (r) begin
            m_inst  = (m_rst || m_nmi || irqr) ? RSTVEC : db;
            m_cycle = 0;
        end else if (!s && i) begin
            if (m_cycle == 7) m_err = 1'b1;
            m_cycle = (m_cycle + 1) % 8;
        end
        m_new = r;
        if (si) begin
            if (m_rst) m_rst = 1'b0;
            else if (m_nmi) m_nmi = 1'b0;
        end
        if (nedge) m_nmi = 1'b1;
        for (int k = 3; k > 0; k--) begin
            ih[k] = ih[k-1];
            nh[k] = nh[k-1];
        end
        ih[0] = bus.irq_pin;
        nh[0] = bus.nmi_pin;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic incs(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag, 0, 0, 1, 0, 8'h00);
    endtask

    initial begin
        bus.databus = 8'h00;
        bus.irq_pin = 1'b0;
        bus.nmi_pin = 1'b0;
        bus.idis    = 1'b1;
        bus.icyc    = 1'b0;
        bus.rcyc    = 1'b0;
        bus.scyc    = 1'b0;
        bus.sinst   = 1'b0;
        model_reset();
        #2;

        // Reset, acknowledge, count to 7
        do_reset("rst");
        check("rst_inst_const", 32'(bus.inst), 32'h00);
        check("rst_rstreq_const", 32'(bus.rstreq), 32'd1);
        step("sinst", 0, 0, 0, 1, 8'h00);
        check("sinst_rstreq_const", 32'(bus.rstreq), 32'd0);
        incs("cnt7", 7);
        check("cnt7_cycle_const", 32'(bus.cycle), 32'd7);
        check("cnt7_err_const", 32'(bus.cycerr), 32'd0);

        // Plain fetch
        step("fetch", 1, 0, 0, 0, 8'h69);
        check("fetch_inst_const", 32'(bus.inst), 32'h69);
        check("fetch_new_const", 32'(bus.newinst), 32'd1);
        step("fetch_after", 0, 0, 1, 0, 8'h00);
        check("fetch_new_drop", 32'(bus.newinst), 32'd0);
        incs("cnt3", 2);
        check("cnt3_cycle_const", 32'(bus.cycle), 32'd3);

        // Strobe priority
        step("pri_r", 1, 0, 0, 0, 8'h69);
        incs("pri_up", 2);
        step("pri_all", 1, 1, 1, 0, 8'h69);
        check("pri_all_cycle", 32'(bus.cycle), 32'd0);
        incs("pri_up2", 2);
        step("pri_si", 0, 1, 1, 0, 8'h69);
        check("pri_si_cycle", 32'(bus.cycle), 32'd2);

        // NMI mid-instruction
        bus.nmi_pin = 1'b1;
        idle("nmi_wait", 2);
        check("nmi_not_yet", 32'(bus.nmireq), 32'd0);
        idle("nmi_arrive", 1);
        check("nmi_req_const", 32'(bus.nmireq), 32'd1);
        check("nmi_inst_hold", 32'(bus.inst), 32'h69);
        step("nmi_fetch", 1, 0, 0, 0, 8'h69);
        check("nmi_fetch_inst", 32'(bus.inst), 32'h00);
        step("nmi_ack", 0, 0, 0, 1, 8'h00);
        check("nmi_ack_req", 32'(bus.nmireq), 32'd0);
        idle("nmi_hold", 4);
        check("nmi_no_retrig", 32'(bus.nmireq), 32'd0);
        bus.nmi_pin = 1'b0;

        // IRQ masking
        bus.irq_pin = 1'b1;
        bus.idis    = 1'b1;
        idle("irq_masked", 3);
        step("irq_mfetch", 1, 0, 0, 0, 8'hA9);
        check("irq_masked_inst", 32'(bus.inst), 32'hA9);
        bus.idis = 1'b0;
        #1;
        check("irq_unmasked", 32'(bus.irqreq), 32'd1);
        step("irq_fetch", 1, 0, 0, 0, 8'hA9);
        check("irq_fetch_inst", 32'(bus.inst), 32'h00);
        bus.irq_pin = 1'b0;
        bus.idis    = 1'b1;
        idle("irq_clear", 3);

        // New NMI edge on the same edge as the clearing sinst
        bus.nmi_pin = 1'b1;
        idle("sim_set", 3);
        bus.nmi_pin = 1'b0;
        idle("sim_low", 3);
        bus.nmi_pin = 1'b1;
        idle("sim_rise", 2);
        step("sim_ack", 0, 0, 0, 1, 8'h00);
        check("sim_setwins", 32'(bus.nmireq), 32'd1);
        step("sim_ack2", 0, 0, 0, 1, 8'h00);
        check("sim_cleared", 32'(bus.nmireq), 32'd0);
        bus.nmi_pin = 1'b0;

        // Wrap error
        step("wrap_r", 1, 0, 0, 0, 8'h11);
        incs("wrap7", 7);
        check("wrap7_err", 32'(bus.cycerr), 32'd0);
        incs("wrap8", 1);
        check("wrap_cycle", 32'(bus.cycle), 32'd0);
        check("wrap_err", 32'(bus.cycerr), 32'd1);

        // Abort at cycle 5
        step("abort_r", 1, 0, 0, 0, 8'h22);
        incs("abort5", 5);
        do_reset("abort");
        check("abort_err", 32'(bus.cycerr), 32'd0);
        check("abort_cycle", 32'(bus.cycle), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 9) == 0) bus.nmi_pin = ~bus.nmi_pin;
            if ($urandom_range(0, 7) == 0) bus.irq_pin = ~bus.irq_pin;
            if ($urandom_range(0, 11) == 0) bus.idis = ~bus.idis;
            if ($urandom_range(0, 249) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step("rnd",
                     $urandom_range(0, 5) == 0,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 1) == 0,
                     $urandom_range(0, 7) == 0,
                     8'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
